operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 191 +++++++++++++++++++
 tb/tb_operand_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// ============================================================================
// Module      : operand_fetch
// Description : RV32I operand-fetch stage. Decodes an instruction, reads the
//               register file, and presents operands through a one-entry
//               output register with writeback bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    input  logic [31:0] register_data_1,
    input  logic [31:0] register_data_2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        write_enable,
    output logic [4:0]  register_write_select,
    output logic [31:0] register_data_write,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [31:0] op_imm,
    output logic [4:0]  op_rd,
    output logic [6:0]  op_opcode,
    output logic [2:0]  op_funct3,
    output logic        op_funct7b5,
    output logic        op_illegal
);

    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;

    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_has_rd;
    logic        w_illegal;
    logic [31:0] w_imm;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic        w_accept;

    logic        r_op_valid;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_op_imm;
    logic [4:0]  r_op_rd;
    logic [6:0]  r_op_opcode;
    logic [2:0]  r_op_funct3;
    logic        r_op_funct7b5;
    logic        r_op_illegal;
    logic [4:0]  r_src1_idx;
    logic [4:0]  r_src2_idx;

    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];

    assign write_enable          = wb_valid && (wb_rd != 5'd0);
    assign register_write_select = wb_rd;
    assign register_data_write   = wb_data;

    assign instr_ready = !r_op_valid || op_ready;
    assign w_accept    = instr_valid && instr_ready;

    assign w_imm_i = {{21{instr[31]}}, instr[30:20]};
    assign w_imm_s = {{21{instr[31]}}, instr[30:25], instr[11:7]};
    assign w_imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u = {instr[31:12], 12'h000};
    assign w_imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_has_rd  = 1'b0;
        w_illegal = 1'b0;
        w_imm     = 32'h0;
        case (instr[6:0])
            C_OPC_LUI, C_OPC_AUIPC: begin
                w_has_rd = 1'b1;
                w_imm    = w_imm_u;
            end
            C_OPC_JAL: begin
                w_has_rd = 1'b1;
                w_imm    = w_imm_j;
            end
            C_OPC_JALR, C_OPC_LOAD, C_OPC_OPIMM: begin
                w_use_rs1 = 1'b1;
                w_has_rd  = 1'b1;
                w_imm     = w_imm_i;
            end
            C_OPC_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm     = w_imm_b;
            end
            C_OPC_STORE: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm     = w_imm_s;
            end
            C_OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_has_rd  = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // x0 and unused sources read as zero; a same-cycle writeback wins over the register file.
    always_comb begin
        w_src1 = 32'h0;
        w_src2 = 32'h0;
        if (w_use_rs1 && (rs1 != 5'd0)) begin
            w_src1 = (write_enable && (wb_rd == rs1)) ? wb_data : register_data_1;
        end
        if (w_use_rs2 && (rs2 != 5'd0)) begin
            w_src2 = (write_enable && (wb_rd == rs2)) ? wb_data : register_data_2;
        end
    end

    // Unused sources store index 0, which write_enable can never match.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_op_valid    <= 1'b0;
            r_op_a        <= 32'h0;
            r_op_b        <= 32'h0;
            r_op_imm      <= 32'h0;
            r_op_rd       <= 5'd0;
            r_op_opcode   <= 7'd0;
            r_op_funct3   <= 3'd0;
            r_op_funct7b5 <= 1'b0;
            r_op_illegal  <= 1'b0;
            r_src1_idx    <= 5'd0;
            r_src2_idx    <= 5'd0;
        end else if (w_accept) begin
            r_op_valid    <= 1'b1;
            r_op_a        <= w_src1;
            r_op_b        <= w_src2;
            r_op_imm      <= w_imm;
            r_op_rd       <= w_has_rd ? instr[11:7] : 5'd0;
            r_op_opcode   <= instr[6:0];
            r_op_funct3   <= instr[14:12];
            r_op_funct7b5 <= instr[30];
            r_op_illegal  <= w_illegal;
            r_src1_idx    <= w_use_rs1 ? rs1 : 5'd0;
            r_src2_idx    <= w_use_rs2 ? rs2 : 5'd0;
        end else if (r_op_valid && op_ready) begin
            r_op_valid <= 1'b0;
        end else if (r_op_valid) begin
            if (write_enable && (wb_rd == r_src1_idx)) begin
                r_op_a <= wb_data;
            end
            if (write_enable && (wb_rd == r_src2_idx)) begin
                r_op_b <= wb_data;
            end
        end
    end

    assign op_valid    = r_op_valid;
    assign op_a        = r_op_a;
    assign op_b        = r_op_b;
    assign op_imm      = r_op_imm;
    assign op_rd       = r_op_rd;
    assign op_opcode   = r_op_opcode;
    assign op_funct3   = r_op_funct3;
    assign op_funct7b5 = r_op_funct7b5;
    assign op_illegal  = r_op_illegal;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module      : tb_operand_fetch
// Description : Randomised scoreboard bench for operand_fetch against a
//               register-file reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] register_data_1;
    logic [31:0] register_data_2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        write_enable;
    logic [4:0]  register_write_select;
    logic [31:0] register_data_write;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_imm;
    logic [4:0]  op_rd;
    logic [6:0]  op_opcode;
    logic [2:0]  op_funct3;
    logic        op_funct7b5;
    logic        op_illegal;

    always #5 clock = ~clock;

    operand_fetch dut (
        .clock                 (clock),
        .reset                 (reset),
        .instr_valid           (instr_valid),
        .instr                 (instr),
        .instr_ready           (instr_ready),
        .rs1                   (rs1),
        .rs2                   (rs2),
        .register_data_1       (register_data_1),
        .register_data_2       (register_data_2),
        .wb_valid              (wb_valid),
        .wb_rd                 (wb_rd),
        .wb_data               (wb_data),
        .write_enable          (write_enable),
        .register_write_select (register_write_select),
        .register_data_write   (register_data_write),
        .op_valid              (op_valid),
        .op_ready              (op_ready),
        .op_a                  (op_a),
        .op_b                  (op_b),
        .op_imm                (op_imm),
        .op_rd                 (op_rd),
        .op_opcode             (op_opcode),
        .op_funct3             (op_funct3),
        .op_funct7b5           (op_funct7b5),
        .op_illegal            (op_illegal)
    );

    typedef struct {
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [31:0] imm;
        logic [16:0] fields;
    } exp_t;

    exp_t        q[$];
    logic [31:0] regs[32];
    logic [31:0] garbage;
    int          checks = 0;
    int          fails  = 0;

    // Architectural register file; x0 reads return junk so the DUT must ignore them.
    always @(posedge clock) begin
        if (wb_valid && (wb_rd != 5'd0)) regs[wb_rd] <= wb_data;
    end

    always_comb begin
        register_data_1 = (rs1 == 5'd0) ? garbage : regs[rs1];
        register_data_2 = (rs2 == 5'd0) ? garbage : regs[rs2];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins);
        exp_t        e;
        logic        ua, ub, ur, ill;
        logic [31:0] imm;
        ua = 1'b0; ub = 1'b0; ur = 1'b0; ill = 1'b0; imm = 32'h0;
        case (ins[6:0])
            7'h37, 7'h17: begin ur = 1'b1; imm = {ins[31:12], 12'h000}; end
            7'h6F: begin
                ur = 1'b1;
                imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'h67, 7'h03, 7'h13: begin
                ua = 1'b1; ur = 1'b1;
                imm = 32'($signed(ins[31:20]));
            end
            7'h63: begin
                ua = 1'b1; ub = 1'b1;
                imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'h23: begin
                ua = 1'b1; ub = 1'b1;
                imm = 32'($signed({ins[31:25], ins[11:7]}));
            end
            7'h33: begin ua = 1'b1; ub = 1'b1; ur = 1'b1; end
            default: ill = 1'b1;
        endcase
        e.s1     = ua ? ins[19:15] : 5'd0;
        e.s2     = ub ? ins[24:20] : 5'd0;
        e.imm    = imm;
        e.fields = {ins[6:0], ins[14:12], ins[30], ill, (ur ? ins[11:7] : 5'd0)};
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 10))
            0: ins[6:0] = 7'h37;  1: ins[6:0] = 7'h17;  2: ins[6:0] = 7'h6F;
            3: ins[6:0] = 7'h67;  4: ins[6:0] = 7'h63;  5: ins[6:0] = 7'h03;
            6: ins[6:0] = 7'h23;  7: ins[6:0] = 7'h13;  8: ins[6:0] = 7'h33;
            9: ins[6:0] = 7'h7F;
            default: ins[6:0] = 7'h0F;
        endcase
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    // Monitor: the operand value of a consumed entry is the register's current architectural value.
    always @(negedge clock) begin
        exp_t e;
        int   pend;
        check("rs1", 32'(rs1), 32'(instr[19:15]));
        check("rs2", 32'(rs2), 32'(instr[24:20]));
        check("write_enable", 32'(write_enable), 32'(wb_valid && (wb_rd != 5'd0)));
        check("wr_select", 32'(register_write_select), 32'(wb_rd));
        check("wr_data", register_data_write, wb_data);
        if (!reset) begin
            check("instr_ready", 32'(instr_ready), 32'(!op_valid || op_ready));
            pend = (instr_valid && instr_ready) ? 1 : 0;
            check("op_valid", 32'(op_valid), 32'((q.size() - pend) > 0));
            if (op_valid && op_ready && (q.size() > pend)) begin
                e = q.pop_front();
                check("op_a", op_a, (e.s1 == 5'd0) ? 32'h0 : regs[e.s1]);
                check("op_b", op_b, (e.s2 == 5'd0) ? 32'h0 : regs[e.s2]);
                check("op_imm", op_imm, e.imm);
                check("op_fields", 32'({op_opcode, op_funct3, op_funct7b5, op_illegal, op_rd}),
                      32'(e.fields));
            end
        end
    end

    task automatic step(input logic rst, input logic iv, input logic [31:0] ins,
                        input logic ordy, input logic wv, input logic [4:0] wrd,
                        input logic [31:0] wd);
        @(posedge clock);
        #1;
        reset = rst; instr_valid = iv; instr = ins; op_ready = ordy;
        wb_valid = wv; wb_rd = wrd; wb_data = wd;
        #1;
        if (reset) q.delete();
        else if (instr_valid && instr_ready) q.push_back(model(instr));
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = 32'h0; op_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; garbage = 32'h0000DEAD;
        step(1, 0, 32'h0, 0, 0, 0, 32'h0);
        step(1, 0, 32'h0, 0, 0, 0, 32'h0);
        check("reset op_valid", 32'(op_valid), 32'h0);
        check("reset op_a", op_a, 32'h0);
        check("reset op_imm", op_imm, 32'h0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0);
        check("ready after reset", 32'(instr_ready), 32'h1);

        for (int i = 1; i < 32; i++) step(0, 0, 32'h0, 1, 1, 5'(i), $urandom);
        step(0, 0, 32'h0, 1, 1, 5'd1, 32'd5);
        step(0, 0, 32'h0, 1, 1, 5'd2, 32'd7);

        // add x2,x1,x2
        step(0, 1, 32'h00208133, 0, 0, 0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0);
        check("add op_valid", 32'(op_valid), 32'h1);
        check("add op_a", op_a, 32'd5);
        check("add op_b", op_b, 32'd7);
        check("add op_rd", 32'(op_rd), 32'd2);
        check("add op_illegal", 32'(op_illegal), 32'h0);
        step(0, 0, 32'h0, 1, 0, 0, 32'h0);

        // addi x3,x0,-1 with junk on the x0 read port
        step(0, 1, 32'hFFF00193, 0, 0, 0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0);
        check("addi op_a", op_a, 32'h0);
        check("addi op_imm", op_imm, 32'hFFFFFFFF);
        check("addi op_b", op_b, 32'h0);
        check("addi op_rd", 32'(op_rd), 32'd3);
        step(0, 0, 32'h0, 1, 0, 0, 32'h0);

        // add x5,x1,x1 with same-cycle writeback to x1
        step(0, 1, 32'h001082B3, 0, 1, 5'd1, 32'h1234);
        check("bypass write_enable", 32'(write_enable), 32'h1);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0);
        check("bypass op_a", op_a, 32'h1234);
        check("bypass op_b", op_b, 32'h1234);
        step(0, 0, 32'h0, 1, 0, 0, 32'h0);

        // add x6,x1,x4 held while x4 is written
        step(0, 1, 32'h00408333, 0, 0, 0, 32'h0);
        step(0, 0, 32'h0, 0, 1, 5'd4, 32'h99);
        check("hold instr_ready", 32'(instr_ready), 32'h0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0);
        check("hold op_b", op_b, 32'h99);
        check("hold instr_ready 2", 32'(instr_ready), 32'h0);
        step(0, 0, 32'h0, 1, 0, 0, 32'h0);

        step(0, 0, 32'h0, 1, 1, 5'd0, 32'h5555);
        check("wb x0 write_enable", 32'(write_enable), 32'h0);
        step(0, 1, 32'hFFFFFFFF, 0, 0, 0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0);
        check("illegal flag", 32'(op_illegal), 32'h1);
        check("illegal op_rd", 32'(op_rd), 32'h0);
        check("illegal op_a", op_a, 32'h0);
        check("illegal op_imm", op_imm, 32'h0);
        step(1, 0, 32'h0, 0, 0, 0, 32'h0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0);
        check("reset mid-hold op_valid", 32'(op_valid), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            garbage = $urandom;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), gen_instr(),
                 ($urandom_range(0, 9) < 6), $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 7)), $urandom);
        end
        for (int n = 0; n < 4; n++) step(0, 0, 32'h0, 1, 0, 0, 32'h0);
        check("scoreboard drained", 32'(q.size()), 32'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

`default_nettype wire
